vga_fetch: RTL

Bus master that streams frame-buffer words from memory into a show-ahead FIFO for the VGA pixel pipeline. Sits directly upstream of the bus controller's VGA master port (drives `vga_read`/`vga_address`, obeys `vga_wait`) and downstream of nothing but the frame base register. The pixel side pops 32-bit words as the scan-out logic needs them. It refills whenever the FIFO has room, and restarts at `base_address` on every `frame_start`.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_fetch_if.sv | 17 +
 rtl/fifo_sync.sv | 95 +++++++++
 rtl/vga_fetch.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the VGA frame-buffer fetch path.
// Contents: bus word size, default 640x480 @ 8 bpp geometry, the derived
// frame size in words, fetch FSM state encodings and an address-step helper.
package vga_pkg;

  localparam int unsigned BYTES_PER_WORD      = 4;
  localparam int unsigned H_ACTIVE            = 640;
  localparam int unsigned V_ACTIVE            = 480;
  localparam int unsigned BITS_PER_PIXEL      = 8;
  localparam int unsigned DEFAULT_FRAME_WORDS =
    (H_ACTIVE * V_ACTIVE * BITS_PER_PIXEL) / (BYTES_PER_WORD * 8);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_GAP   = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  // Byte address of the word that follows addr (wraps at 32 bits).
  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return addr + 32'(BYTES_PER_WORD);
  endfunction

endpackage

// File: rtl/vga_fetch_if.sv
// vga_fetch_if: read-only bus port between the VGA fetch master and the bus
// controller's VGA master port.
//   vga_read     master->slave  read request, held until data returns
//   vga_address  master->slave  byte address of the request
//   vga_wait     slave->master  low while bus_readdata is valid
//   bus_readdata slave->master  read data
interface vga_fetch_if;
  logic        vga_read;
  logic [31:0] vga_address;
  logic        vga_wait;
  logic [31:0] bus_readdata;

  modport master (output vga_read, output vga_address,
                  input  vga_wait, input  bus_readdata);
  modport slave  (input  vga_read, input  vga_address,
                  output vga_wait, output bus_readdata);
endinterface

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock show-ahead FIFO. dout is a register that always
// holds the head word; it keeps its last value while the FIFO is empty.
//   clock/reset  rising-edge clock, async active-high reset
//   push/din     write din when not full (or when a pop frees a slot)
//   pop          drop the head word; ignored while empty
//   flush        empty the FIFO; wins over push and pop
//   dout/count/empty/full  head word and occupancy
module fifo_sync #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == CNT_ZERO);
  assign full    = (count_q == CNT_FULL);
  assign pop_ok  = pop && !empty && !flush;
  assign push_ok = push && (!full || pop_ok) && !flush;
  assign count   = count_q;
  assign dout    = dout_q;

  // Next pointers, occupancy and head word.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (flush) begin
      rd_ptr_d = {AW{1'b0}};
      wr_ptr_d = {AW{1'b0}};
      count_d  = CNT_ZERO;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      else         wr_ptr_d = wr_ptr_q;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      else         rd_ptr_d = rd_ptr_q;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      // The word behind the head is already stored when count >= 2; with a
      // single entry the incoming word (if any) becomes the new head.
      if (pop_ok) begin
        if (count_q > CNT_ONE) dout_d = mem_q[rd_ptr_q + PTR_ONE];
        else if (push_ok)      dout_d = din;
        else                   dout_d = dout_q;
      end else if (empty && push_ok) begin
        dout_d = din;
      end else begin
        dout_d = dout_q;
      end
    end
  end

  // Storage array; no reset needed, occupancy guards every read.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  // Pointer, count and head registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      count_q  <= CNT_ZERO;
      dout_q   <= {WIDTH{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end
endmodule

// File: rtl/vga_fetch.sv
// vga_fetch: bus master streaming frame-buffer words into a show-ahead FIFO.
//   clock/reset   rising-edge clock, async active-high reset
//   enable        fetch allowed; sampled at frame_start
//   base_address  frame base byte address; latched at frame_start
//   frame_start   one-cycle pulse restarting the frame fetch
//   bus           master side of vga_fetch_if (vga_read/vga_address out,
//                 vga_wait/bus_readdata in)
//   pix_pop       consume the head word
//   pix_data      head word, pix_valid FIFO not empty
//   underflow     sticky flag, pix_pop seen while empty; cleared on restart
module vga_fetch import vga_pkg::*; #(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned FRAME_WORDS = DEFAULT_FRAME_WORDS
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] base_address,
  input  logic        frame_start,
  vga_fetch_if.master bus,
  input  logic        pix_pop,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  output logic        underflow
);
  localparam int unsigned WL_W  = $clog2(FRAME_WORDS + 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [WL_W-1:0]  WL_FULL   = WL_W'(FRAME_WORDS);
  localparam logic [WL_W-1:0]  WL_ZERO   = {WL_W{1'b0}};
  localparam logic [WL_W-1:0]  WL_ONE    = WL_W'(1'b1);

  fetch_state_e      state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [WL_W-1:0]   words_left_q, words_left_d;
  logic              underflow_q, underflow_d;
  logic              pend_en_q, pend_en_d;
  logic [31:0]       pend_base_q, pend_base_d;
  logic              read_q, read_d;

  logic              restart, rs_en;
  logic [31:0]       rs_base;
  logic              fifo_push, fifo_flush, fifo_empty, fifo_full;
  logic [CNT_W-1:0]  fifo_count;

  fifo_sync #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (pix_pop),
    .flush (fifo_flush),
    .din   (bus.bus_readdata),
    .dout  (pix_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.vga_read    = read_q;
  assign bus.vga_address = addr_q;
  assign pix_valid       = !fifo_empty;
  assign underflow       = underflow_q;

  // Fetch FSM next state, frame counters and restart handling.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    pend_en_d    = pend_en_q;
    pend_base_d  = pend_base_q;
    underflow_d  = underflow_q;
    fifo_push    = 1'b0;
    fifo_flush   = 1'b0;
    restart      = 1'b0;
    rs_en        = enable;
    rs_base      = base_address;

    case (state_q)
      ST_IDLE: begin
        if (frame_start) restart = 1'b1;
        else             state_d = ST_IDLE;
      end
      ST_GAP: begin
        if (frame_start)                    restart = 1'b1;
        else if (words_left_q == WL_ZERO)   state_d = ST_IDLE;
        else if (fifo_count < DEPTH_CNT)    state_d = ST_REQ;
        else                                state_d = ST_GAP;
      end
      ST_REQ: begin
        if (frame_start) begin
          // Data returning in this very cycle is simply discarded.
          if (!bus.vga_wait) begin
            restart = 1'b1;
          end else begin
            pend_en_d   = enable;
            pend_base_d = base_address;
            state_d     = ST_DRAIN;
          end
        end else if (!bus.vga_wait) begin
          fifo_push    = !fifo_full;
          addr_d       = next_word_addr(addr_q);
          words_left_d = words_left_q - WL_ONE;
          state_d      = ST_GAP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DRAIN: begin
        // A later frame_start overrides the one that started the drain.
        if (frame_start) begin
          pend_en_d   = enable;
          pend_base_d = base_address;
        end else begin
          pend_en_d   = pend_en_q;
          pend_base_d = pend_base_q;
        end
        if (!bus.vga_wait) begin
          restart = 1'b1;
          rs_en   = frame_start ? enable : pend_en_q;
          rs_base = frame_start ? base_address : pend_base_q;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Restart flushes the FIFO, so it also masks a pix_pop in the same cycle.
    if (restart) begin
      fifo_flush  = 1'b1;
      underflow_d = 1'b0;
      if (rs_en) begin
        addr_d       = rs_base;
        words_left_d = WL_FULL;
        state_d      = ST_GAP;
      end else begin
        words_left_d = WL_ZERO;
        state_d      = ST_IDLE;
      end
    end else begin
      underflow_d = underflow_q | (pix_pop & fifo_empty);
    end

    read_d = (state_d == ST_REQ) || (state_d == ST_DRAIN);
  end

  // FSM and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= 32'h0000_0000;
      words_left_q <= WL_ZERO;
      underflow_q  <= 1'b0;
      pend_en_q    <= 1'b0;
      pend_base_q  <= 32'h0000_0000;
      read_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      words_left_q <= words_left_d;
      underflow_q  <= underflow_d;
      pend_en_q    <= pend_en_d;
      pend_base_q  <= pend_base_d;
      read_q       <= read_d;
    end
  end
endmodule
